// File: rtl/fp_mc_wb_arbiter_pkg.sv
// Shared FP multicycle writeback types: control bus layout and unit indices.
package fp_mc_wb_arbiter_pkg;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
      logic       FP_reg_write;
      logic       mem_to_reg;
   } exe_p_mux_bus_type;

   localparam int BUS_W       = $bits(exe_p_mux_bus_type);
   localparam int FP_MC_UNITS = 3;
   localparam int FP_MC_DIV   = 0;
   localparam int FP_MC_SQRT  = 1;

endpackage

// File: rtl/Register.sv
// Generic state cell: async active-low reset, sync clear (wins over en), load enable.
module Register #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     q <= RST_VAL;
      else if (clear) q <= '0;
      else if (en)    q <= d;
   end

endmodule

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, cyclically.
module fp_rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   // Walk from farthest to nearest so the nearest requester overwrites the rest.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      for (int i = N; i >= 1; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            grant                         = '0;
            grant[(int'(ptr) + i) % N]    = 1'b1;
            grant_idx                     = IDX_W'((int'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/fp_mc_wb_arbiter.sv
// Writeback collector for multicycle FP units: 1-entry slot per unit, round-robin
// onto one registered writeback port, stall back to any unit holding an unsent result.
module fp_mc_wb_arbiter
   import fp_mc_wb_arbiter_pkg::*;
#(
   parameter int NUM_UNITS = FP_MC_UNITS,
   parameter int DATA_W    = 32,
   parameter int SRC_W     = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               clear,
   input  logic                               en,
   input  logic [NUM_UNITS-1:0]               p_i,
   input  logic [NUM_UNITS-1:0][DATA_W-1:0]   result_i,
   input  logic [NUM_UNITS-1:0][BUS_W-1:0]    bus_i,
   output logic [NUM_UNITS-1:0]               stall_o,
   input  logic                               wb_ready_i,
   output logic                               p_o,
   output logic [DATA_W-1:0]                  result_o,
   output logic [BUS_W-1:0]                   bus_o,
   output logic [SRC_W-1:0]                   src_o,
   output logic                               busy_o
);

   localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   logic [NUM_UNITS-1:0]             slot_v, arb_grant, grant, capture, rel;
   logic [NUM_UNITS-1:0][DATA_W-1:0] slot_data;
   logic [NUM_UNITS-1:0][BUS_W-1:0]  slot_bus;
   logic [IDX_W-1:0]                 ptr, grant_idx;
   logic                             out_free, load, any_grant;

   fp_rr_arbiter #(.N(NUM_UNITS), .IDX_W(IDX_W)) u_arb (
      .req       (slot_v),
      .ptr       (ptr),
      .grant     (arb_grant),
      .grant_idx (grant_idx)
   );

   assign out_free  = !p_o || wb_ready_i;
   assign load      = en && out_free;
   assign grant     = load ? arb_grant : '0;
   assign any_grant = |grant;

   // A slot accepts a new pulse when empty or when its current entry leaves this cycle.
   assign capture   = (en && !clear) ? (p_i & (~slot_v | grant)) : '0;
   assign rel       = grant & ~p_i;
   assign stall_o   = slot_v & ~grant;
   assign busy_o    = (|slot_v) || p_o;

   for (genvar k = 0; k < NUM_UNITS; k++) begin : g_slot
      Register #(.W(1)) u_v (
         .clk, .rst_n, .clear,
         .en (capture[k] | rel[k]),
         .d  (capture[k]),
         .q  (slot_v[k])
      );
      Register #(.W(DATA_W)) u_data (
         .clk, .rst_n, .clear,
         .en (capture[k]),
         .d  (result_i[k]),
         .q  (slot_data[k])
      );
      Register #(.W(BUS_W)) u_bus (
         .clk, .rst_n, .clear,
         .en (capture[k]),
         .d  (bus_i[k]),
         .q  (slot_bus[k])
      );
   end

   Register #(.W(1)) u_p (
      .clk, .rst_n, .clear,
      .en (load),
      .d  (any_grant),
      .q  (p_o)
   );
   Register #(.W(DATA_W)) u_res (
      .clk, .rst_n, .clear,
      .en (load && any_grant),
      .d  (slot_data[grant_idx]),
      .q  (result_o)
   );
   Register #(.W(BUS_W)) u_bus_o (
      .clk, .rst_n, .clear,
      .en (load && any_grant),
      .d  (slot_bus[grant_idx]),
      .q  (bus_o)
   );
   Register #(.W(SRC_W)) u_src (
      .clk, .rst_n, .clear,
      .en (load && any_grant),
      .d  (SRC_W'(grant_idx)),
      .q  (src_o)
   );

   // Pointer survives a flush so fairness is not reset by pipeline clears.
   Register #(.W(IDX_W), .RST_VAL(IDX_W'(NUM_UNITS - 1))) u_ptr (
      .clk, .rst_n,
      .clear (1'b0),
      .en    (load && any_grant),
      .d     (grant_idx),
      .q     (ptr)
   );

   a_no_pulse_while_stalled: assert property (
      @(posedge clk) disable iff (!rst_n) !(en && !clear && (|(p_i & stall_o))));

endmodule

// File: tb/tb_fp_mc_wb_arbiter.sv
// Bench for fp_mc_wb_arbiter: per-unit scoreboard queues plus directed ordering checks.
module tb_fp_mc_wb_arbiter;
   import fp_mc_wb_arbiter_pkg::*;

   localparam int N  = FP_MC_UNITS;
   localparam int DW = 32;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0, clear = 1'b0, en = 1'b0, wb_ready_i = 1'b0;
   logic [N-1:0]             p_i = '0;
   logic [N-1:0][DW-1:0]     result_i = '0;
   logic [N-1:0][BUS_W-1:0]  bus_i = '0;
   logic [N-1:0]             stall_o;
   logic                     p_o, busy_o;
   logic [DW-1:0]            result_o;
   logic [BUS_W-1:0]         bus_o;
   logic [1:0]               src_o;

   typedef struct packed {
      logic [DW-1:0]    data;
      logic [BUS_W-1:0] bus;
   } sb_t;

   sb_t sbq [N][$];
   int  n_chk = 0, n_err = 0;

   fp_mc_wb_arbiter #(.NUM_UNITS(N), .DATA_W(DW), .SRC_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .en         (en),
      .p_i        (p_i),
      .result_i   (result_i),
      .bus_i      (bus_i),
      .stall_o    (stall_o),
      .wb_ready_i (wb_ready_i),
      .p_o        (p_o),
      .result_o   (result_o),
      .bus_o      (bus_o),
      .src_o      (src_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: accepted pulses pushed per unit, writeback handshakes popped by src_o.
   always @(negedge clk) begin
      sb_t e;
      if (rst_n) begin
         if (clear) begin
            for (int k = 0; k < N; k++) sbq[k].delete();
         end else if (en) begin
            if (p_o && wb_ready_i) begin
               chk("src_range", src_o < N, 1);
               if (src_o < N) begin
                  chk("sb_avail", sbq[src_o].size() != 0, 1);
                  if (sbq[src_o].size() != 0) begin
                     e = sbq[src_o].pop_front();
                     chk("sb_data", result_o, e.data);
                     chk("sb_bus", bus_o, e.bus);
                  end
               end
            end
            for (int k = 0; k < N; k++)
               if (p_i[k] && !stall_o[k]) sbq[k].push_back({result_i[k], bus_i[k]});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] p);
      p_i = p;
      for (int k = 0; k < N; k++)
         if (p[k]) begin
            result_i[k] = $urandom;
            bus_i[k]    = BUS_W'($urandom);
         end
   endtask

   logic [BUS_W-1:0]         exp_bus;
   logic [N-1:0][DW-1:0]     d_first;
   logic [N-1:0][BUS_W-1:0]  b_first;
   logic [N-1:0]             g_mask;
   int                       g, last;

   initial begin
      repeat (2) cyc();
      chk("rst_p_o", p_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_bus", bus_o, 0);
      chk("rst_src", src_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_stall", stall_o, 0);
      rst_n = 1'b1; en = 1'b1; wb_ready_i = 1'b1;
      cyc();

      // single result from fsqrt
      drive(3'b010);
      result_i[FP_MC_SQRT] = 32'h3FB504F3;
      exp_bus = bus_i[FP_MC_SQRT];
      #1 chk("single_stall_a", stall_o, 0);
      cyc();
      p_i = '0;
      #1 chk("single_stall_b", stall_o, 0);
      chk("single_lat", p_o, 0);
      cyc();
      chk("single_p_o", p_o, 1);
      chk("single_res", result_o, 32'h3FB504F3);
      chk("single_src", src_o, FP_MC_SQRT);
      chk("single_bus", bus_o, exp_bus);
      chk("single_stall_c", stall_o, 0);
      cyc();
      chk("single_idle", p_o, 0);
      chk("single_busy", busy_o, 0);

      // contention: both fdiv and fsqrt in one cycle
      drive(3'b011);
      cyc();
      p_i = '0;
      #1 chk("cont_stall_1", stall_o, 3'b010);
      cyc();
      chk("cont_p_o_0", p_o, 1);
      chk("cont_src_0", src_o, FP_MC_DIV);
      #1 chk("cont_stall_2", stall_o, 3'b000);
      cyc();
      chk("cont_p_o_1", p_o, 1);
      chk("cont_src_1", src_o, FP_MC_SQRT);
      cyc();
      chk("cont_idle", p_o, 0);

      // fairness: units 0 and 1 re-pulse whenever not stalled
      last = -1;
      for (int c = 0; c < 12; c++) begin
         drive(~stall_o & 3'b011);
         if (p_o) begin
            if (last >= 0) chk("fair_alt", src_o, 1 - last);
            last = int'(src_o);
         end
         cyc();
      end
      p_i = '0;
      repeat (4) cyc();
      chk("fair_idle", busy_o, 0);

      // back-pressure with all three slots full
      wb_ready_i = 1'b0;
      drive(3'b111);
      d_first = result_i;
      b_first = bus_i;
      cyc();
      chk("bp_one_granted", $countones(stall_o), 2);
      g_mask = ~stall_o & 3'b111;
      g = 0;
      for (int k = 0; k < N; k++) if (g_mask[k]) g = k;
      drive(g_mask);
      cyc();
      p_i = '0;
      for (int c = 0; c < 5; c++) begin
         chk("bp_stall", stall_o, 3'b111);
         chk("bp_p_o", p_o, 1);
         chk("bp_res", result_o, d_first[g]);
         chk("bp_bus", bus_o, b_first[g]);
         chk("bp_src", src_o, g);
         cyc();
      end
      wb_ready_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cyc();
         chk("bp_drain", p_o, 1);
      end
      cyc();
      chk("bp_drained", p_o, 0);
      chk("bp_busy", busy_o, 0);

      // en low mid-drain
      drive(3'b111);
      cyc();
      p_i = '0;
      cyc();
      chk("en_p_o", p_o, 1);
      en = 1'b0;
      #1 chk("en_stall", $countones(stall_o), 2);
      for (int c = 0; c < 4; c++) begin
         cyc();
         chk("en_hold_p_o", p_o, 1);
         chk("en_hold_busy", busy_o, 1);
         chk("en_hold_stall", $countones(stall_o), 2);
      end
      en = 1'b1;
      repeat (4) cyc();
      chk("en_drained", busy_o, 0);

      // flush with two slots valid and a fresh pulse on the spare unit
      drive(3'b011);
      cyc();
      drive(3'b100);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      p_i = '0;
      chk("flush_p_o", p_o, 0);
      chk("flush_busy", busy_o, 0);
      for (int c = 0; c < 3; c++) begin
         cyc();
         chk("flush_quiet", p_o, 0);
      end

      for (int k = 0; k < N; k++) chk("sb_leftover", sbq[k].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
